// File: rtl/act_row_writer_if.sv
// Row-in / beat-out bundle for act_row_writer: the row handshake from the activation stage
// and the write-beat handshake toward the feature-map buffer.
interface act_row_writer_if #(
  parameter int DATA_WIDTH = 11,
  parameter int SA_LENGTH  = 256,
  parameter int LANES      = 16,
  parameter int ADDR_WIDTH = 16
);
  logic signed [DATA_WIDTH-1:0] in_row [SA_LENGTH];
  logic        [ADDR_WIDTH-1:0] in_base_addr;
  logic                         in_valid;
  logic                         in_ready;
  logic signed [DATA_WIDTH-1:0] wr_data [LANES];
  logic        [ADDR_WIDTH-1:0] wr_addr;
  logic                         wr_valid;
  logic                         wr_ready;
  logic                         busy;
  logic                         row_done;

  modport master (
    output in_row, in_base_addr, in_valid, wr_ready,
    input  in_ready, wr_data, wr_addr, wr_valid, busy, row_done
  );

  modport slave (
    input  in_row, in_base_addr, in_valid, wr_ready,
    output in_ready, wr_data, wr_addr, wr_valid, busy, row_done
  );
endinterface

// File: rtl/act_row_writer.sv
// Captures one activated row per handshake and streams it to the output buffer as
// LANES-wide beats at consecutive addresses, accepting the next row during the last beat.
module act_row_writer #(
  parameter int DATA_WIDTH = 11,
  parameter int SA_LENGTH  = 256,
  parameter int LANES      = 16,
  parameter int ADDR_WIDTH = 16
) (
  input logic             clk,
  input logic             sync_rst,
  act_row_writer_if.slave bus
);
  localparam int BEATS = SA_LENGTH / LANES;
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int IW    = (SA_LENGTH > 1) ? $clog2(SA_LENGTH) : 1;
  localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t                       state_q;
  logic        [CW-1:0]         cnt_q;
  logic        [ADDR_WIDTH-1:0] base_q;
  logic signed [DATA_WIDTH-1:0] row_q [SA_LENGTH];
  logic                         rdy_en_q;
  logic                         row_done_q;

  logic                         last_beat;
  logic                         beat_fire;
  logic                         row_accept;
  logic signed [DATA_WIDTH-1:0] beat_data [LANES];

  assign last_beat  = (state_q == SEND) && (cnt_q == LAST_BEAT);
  assign beat_fire  = (state_q == SEND) && bus.wr_ready;
  // The only combinational path into in_ready is wr_ready during the last beat.
  assign bus.in_ready = ((state_q == IDLE) && rdy_en_q) || (last_beat && bus.wr_ready);
  assign row_accept = bus.in_ready && bus.in_valid;

  always_ff @(posedge clk) begin
    if (sync_rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      base_q     <= '0;
      rdy_en_q   <= 1'b0;
      row_done_q <= 1'b0;
      for (int i = 0; i < SA_LENGTH; i++) begin
        row_q[i] <= '0;
      end
    end else begin
      rdy_en_q   <= 1'b1;
      row_done_q <= beat_fire && last_beat;
      if (row_accept) begin
        row_q   <= bus.in_row;
        base_q  <= bus.in_base_addr;
        cnt_q   <= '0;
        state_q <= SEND;
      end else if (beat_fire) begin
        if (last_beat) begin
          state_q <= IDLE;
        end else begin
          cnt_q <= cnt_q + CW'(1);
        end
      end
    end
  end

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic [IW-1:0] elem_idx;
    assign elem_idx      = IW'(int'(cnt_q) * LANES + gi);
    assign beat_data[gi] = row_q[elem_idx];
  end

  assign bus.wr_data  = beat_data;
  assign bus.wr_addr  = base_q + ADDR_WIDTH'(cnt_q);
  assign bus.wr_valid = (state_q == SEND);
  assign bus.busy     = (state_q == SEND);
  assign bus.row_done = row_done_q;
endmodule

// File: doc/act_row_writer.md
Name: act_row_writer

Overview:
- Consumer of the registered activation row. Captures one full SA_LENGTH-wide activated row per handshake.
- Streams the row to the output/feature-map buffer as LANES-wide write beats, with valid/ready backpressure.
- Generates beat addresses from a per-row base address.
- Supports back-to-back rows with no idle cycle between them.

Parameters:
- DATA_WIDTH, 11, width of each signed element (matches activation stage).
- SA_LENGTH, 256, elements per row (systolic array width).
- LANES, 16, elements per write beat. SA_LENGTH must be an integer multiple of LANES.
- ADDR_WIDTH, 16, buffer address width, in beats.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- sync_rst  in  1  synchronous active-high reset.
- in_row  in  DATA_WIDTH x SA_LENGTH (signed, unpacked array)  activated row.
- in_base_addr  in  ADDR_WIDTH  buffer address of the row's first beat.
- in_valid  in  1  row and base address are valid.
- in_ready  out  1  writer can accept a row this cycle.
- wr_data  out  DATA_WIDTH x LANES (signed, unpacked array)  beat data.
- wr_addr  out  ADDR_WIDTH  beat address.
- wr_valid  out  1  beat valid.
- wr_ready  in  1  buffer accepts the beat.
- busy  out  1  a row is held and not yet fully written.
- row_done  out  1  one-cycle pulse after the last beat of a row is accepted.

Behaviour:
- Reset (sync_rst=1 at a clock edge) has priority over all other inputs, including mid-row.
  - State goes to IDLE and beat counter to 0.
  - wr_valid=0, busy=0, row_done=0, in_ready=0 during the reset cycle.
  - wr_data and wr_addr are 0.
  - Any partially written row is discarded; no further beats of it are issued.
- BEATS = SA_LENGTH/LANES. Beat counter width is $clog2(BEATS), minimum 1.
- States:
  - IDLE: in_ready=1, wr_valid=0, busy=0. When in_valid=1, latch in_row into the row register and in_base_addr into the address register, clear the counter, and go to SEND.
  - SEND: wr_valid=1, busy=1.
    - wr_data[j] = row_reg[cnt*LANES + j] for j = 0..LANES-1.
    - wr_addr = base_reg + cnt, modulo 2^ADDR_WIDTH (wrap, no saturation).
- Handshake and hold:
  - A beat transfers on a rising edge with wr_valid=1 and wr_ready=1. cnt then increments.
  - While wr_ready=0, wr_data, wr_addr and wr_valid are held stable.
  - wr_valid never drops until the beat is accepted.
- First beat latency: in_valid is accepted at edge N, and wr_valid=1 with beat 0 is visible from edge N until the following edge.
- Last beat (cnt=BEATS-1) accepted:
  - row_done=1 for exactly the next cycle.
  - in_ready=1 combinationally during the last-beat cycle, only when wr_ready=1. It may depend on wr_ready; it has no other combinational input paths.
  - If in_valid=1 in that same cycle, the new row and base are latched, cnt goes to 0, and the state stays SEND. Beat 0 of the new row is presented the next cycle (zero bubble).
  - Otherwise the state goes to IDLE.
- In SEND outside the last-beat condition, in_ready=0 and in_row is ignored.
- Changes to in_row after acceptance have no effect; the row register is isolated from it.
- Element values pass unmodified: no rounding, saturation or sign change.
- BEATS=1 (LANES=SA_LENGTH): every accepted beat is a last beat. row_done pulses after each beat, and rows can stream one per cycle.
- All outputs except in_ready are registered or decoded from registers only.

Test Plan:
Configuration for these scenarios unless noted: DATA_WIDTH=11, SA_LENGTH=8, LANES=2 (BEATS=4).
- Basic row:
  - Stimulus: in_row = {0,1,...,7}, base 0x0010, wr_ready held 1.
  - Response: 4 consecutive beats, addr 0x10..0x13, data {0,1},{2,3},{4,5},{6,7}; row_done one cycle after the 4th beat; return to IDLE with in_ready=1.
- Backpressure:
  - Stimulus: same row; wr_ready = 1,0,0,1,0,1,1.
  - Response: beat 1 (data {2,3}, addr 0x11) is held stable across both stall cycles; exactly 4 transfers with no duplicates or skips.
- Back-to-back rows:
  - Stimulus: row A {-1,-2,...,-8} at base 0x0000; row B {100..107} at base 0x0020, in_valid held high.
  - Response: row B is accepted in A's last-beat cycle; beats run 0x00..0x03 then 0x20..0x23 with no idle cycle; row_done pulses twice.
- Address wrap:
  - Stimulus: base 0xFFFE.
  - Response: addresses 0xFFFE, 0xFFFF, 0x0000, 0x0001.
- Reset mid-row:
  - Stimulus: sync_rst=1 for one cycle after beat 1 is accepted.
  - Response: next cycle wr_valid=0, busy=0, in_ready=0; the cycle after, in_ready=1. No further beats of the old row; no row_done.
- Signed extremes, SA_LENGTH=LANES=8:
  - Stimulus: row {-1024, 1023, 0, -1, 1, 512, -512, 7}.
  - Response: one beat carrying those values exactly; row_done pulses after it.
